// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//   Time-multiplexes one external 32-bit InvMixColumns column unit across the
//   NCOL columns of an AES state. A state is accepted over valid/ready. One
//   column is presented to the column unit per cycle. The results are collected
//   and returned over valid/ready. Bypass mode passes a state straight through
//   for the final decryption round, which has no InvMixColumns.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous abort; drops any in-flight or held state
//   in_valid   input state valid
//   in_ready   a state can be accepted this cycle
//   in_state   input state; column c = bits [32*(NCOL-c)-1 -: 32], col 0 = MSBs
//   bypass     sampled with in_state; 1 = pass through unchanged
//   mc_col_o   column presented to the shared column unit (0 outside RUN)
//   mc_res_i   column unit result, combinational from mc_col_o
//   col_idx    index of the column currently on mc_col_o
//   busy       high while in RUN
//   out_valid  output state valid
//   out_ready  downstream accepts output
//   out_state  transformed state, same column layout as in_state
//
// States
//   state  | meaning
//   IDLE   | empty, waiting for an input state
//   RUN    | walking columns 0..NCOL-1 through the column unit
//   DONE   | result held on out_state with out_valid=1 until taken
// -----------------------------------------------------------------------------
module inv_mix_columns_seq #(
  parameter  int NCOL = 4,
  localparam int SW   = 32 * NCOL,
  localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_state,
  input  logic          bypass,
  output logic [31:0]   mc_col_o,
  input  logic [31:0]   mc_res_i,
  output logic [CW-1:0] col_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q,   col_d;
  logic [SW-1:0] src_q,   src_d;
  logic [SW-1:0] res_q,   res_d;
  logic          accept;

  // Bit offset of the MSB of the current column; column 0 sits at the top.
  int col_msb;
  always_comb col_msb = SW - 1 - 32 * int'(col_q);

  always_comb begin
    in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    accept   = in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    src_d   = src_q;
    res_d   = res_q;

    if (flush) begin
      state_d = S_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bypass) begin
              res_d   = in_state;
              state_d = S_DONE;
            end else begin
              src_d   = in_state;
              col_d   = '0;
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          res_d[col_msb -: 32] = mc_res_i;
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d = col_q + CW'(1);
          end
        end

        S_DONE: begin
          // Completing the output and accepting the next state share one edge,
          // so back-to-back states see no idle cycle.
          if (out_ready) begin
            if (accept) begin
              if (bypass) begin
                res_d   = in_state;
                state_d = S_DONE;
              end else begin
                src_d   = in_state;
                col_d   = '0;
                state_d = S_RUN;
              end
            end else begin
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          col_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    mc_col_o = '0;
    if (state_q == S_RUN) begin
      mc_col_o = src_q[col_msb -: 32];
    end
  end

  assign col_idx   = col_q;
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign out_state = res_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  localparam int NCOL = 4;
  localparam int SW   = 32 * NCOL;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, bypass;
  logic [SW-1:0] in_state, out_state;
  logic [31:0]   mc_col_o, mc_res_i;
  logic [1:0]    col_idx;
  logic          busy, out_valid, out_ready;
  bit            unit_fwd;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.NCOL(NCOL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .bypass(bypass),
    .mc_col_o(mc_col_o), .mc_res_i(mc_res_i), .col_idx(col_idx), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Column transform: circulant matrix (forward MixColumns or InvMixColumns).
  function automatic logic [31:0] col_xf(input logic [31:0] c, input bit fwd);
    logic [7:0] a [4];
    logic [7:0] m [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    if (fwd) m = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gmul(m[(j - i + 4) % 4], a[j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic logic [SW-1:0] state_xf(input logic [SW-1:0] s, input bit fwd);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < NCOL; c++) r[SW-1-32*c -: 32] = col_xf(s[SW-1-32*c -: 32], fwd);
    return r;
  endfunction

  function automatic logic [SW-1:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // The external column unit. The known-answer vector uses the forward
  // matrix and its inverse check uses InvMixColumns, so the unit is switchable.
  assign mc_res_i = col_xf(mc_col_o, unit_fwd);

  localparam logic [SW-1:0] KA_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [SW-1:0] KA_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one state for exactly one edge; the caller ensures in_ready.
  task automatic send(input logic [SW-1:0] s, input bit byp);
    in_state = s;
    bypass   = byp;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = rnd_state();
    bypass   = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (col_idx !== 2'd0) begin bad++; $display("FAIL reset_col_idx: got %0d want 0", col_idx); end
    total++; if (out_state !== '0) begin bad++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    total++; if (mc_col_o !== 32'h0) begin bad++; $display("FAIL reset_mc_col: got %h want 0", mc_col_o); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vector();
    unit_fwd  = 1'b1;
    out_ready = 1'b1;
    send(KA_IN, 1'b0);
    for (int k = 0; k < NCOL; k++) begin
      @(negedge clk);
      total++; if (col_idx !== k[1:0]) begin bad++; $display("FAIL vec_col_idx: got %0d want %0d", col_idx, k); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL vec_busy: got %b want 1", busy); end
      total++; if (mc_col_o !== KA_IN[SW-1-32*k -: 32]) begin bad++; $display("FAIL vec_mc_col: got %h want %h", mc_col_o, KA_IN[SW-1-32*k -: 32]); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec_early_valid: got %b want 0", out_valid); end
      tick();
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec_latency: got %b want 1", out_valid); end
    total++; if (out_state !== KA_OUT) begin bad++; $display("FAIL vec_result: got %h want %h", out_state, KA_OUT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL vec_busy_done: got %b want 0", busy); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec_valid_drop: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vec_idle_ready: got %b want 1", in_ready); end
    tick();
    unit_fwd = 1'b0;
    send(KA_OUT, 1'b0);
    repeat (NCOL) tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inv_latency: got %b want 1", out_valid); end
    total++; if (out_state !== KA_IN) begin bad++; $display("FAIL inv_result: got %h want %h", out_state, KA_IN); end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] s, e;
    int errs;
    unit_fwd  = 1'b0;
    out_ready = 1'b0;
    s = rnd_state();
    e = state_xf(s, 1'b0);
    send(s, 1'b0);
    repeat (NCOL) tick();
    in_valid = 1'b1;
    in_state = rnd_state();
    bypass   = 1'b0;
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_state !== e || in_ready !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b busy=%b state=%h want %h", k, out_valid, in_ready, busy, out_state, e);
      end
      tick();
    end
    total++; if (errs != 0) bad++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %b want 1", out_valid); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_hs: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] s [3];
    logic [SW-1:0] e [3];
    int acc_cyc [3];
    int cyc, sent, got;
    bit acc, hs;
    unit_fwd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s[i] = rnd_state();
      e[i] = state_xf(s[i], 1'b0);
    end
    cyc = 0; sent = 0; got = 0;
    in_state  = s[0];
    bypass    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        total++; if (out_state !== e[got]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, out_state, e[got]); end
        // Result visible the cycle after the NCOL-th edge following its accept.
        total++; if (cyc != acc_cyc[got] + NCOL + 1) begin bad++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", got, cyc, acc_cyc[got] + NCOL + 1); end
        if (got < 2) begin
          total++; if (!acc) begin bad++; $display("FAIL b2b_bubble[%0d]: got in_ready=%b want 1", got, in_ready); end
        end
        got++;
      end
      if (acc) begin
        acc_cyc[sent] = cyc;
        sent++;
      end
      tick();
      cyc++;
      if (sent < 3) in_state = s[sent];
      else          in_valid = 1'b0;
    end
    total++; if (got != 3) begin bad++; $display("FAIL b2b_timeout: got %0d outputs want 3", got); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    logic [SW-1:0] s, s1, s2;
    int errs;
    s = 128'h00112233_44556677_8899aabb_ccddeeff;
    out_ready = 1'b0;
    send(s, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_latency: got %b want 1", out_valid); end
    total++; if (out_state !== s) begin bad++; $display("FAIL byp_data: got %h want %h", out_state, s); end
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      if (busy !== 1'b0 || mc_col_o !== 32'h0) begin
        errs++;
        $display("FAIL byp_idle_unit: busy=%b mc_col=%h want 0 0", busy, mc_col_o);
      end
      tick();
      @(negedge clk);
    end
    total++; if (errs != 0) bad++;
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL byp_release: got %b want 0", out_valid); end
    tick();
    s1 = rnd_state();
    s2 = rnd_state();
    in_state = s1; bypass = 1'b1; in_valid = 1'b1;
    tick();
    in_state = s2;
    @(negedge clk);
    total++; if (out_state !== s1) begin bad++; $display("FAIL byp_b2b_first: got %h want %h", out_state, s1); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL byp_b2b_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_state !== s2) begin bad++; $display("FAIL byp_b2b_second: got v=%b %h want 1 %h", out_valid, out_state, s2); end
    tick();
    tick();
  endtask

  task automatic test_reset_midop();
    unit_fwd  = 1'b1;
    out_ready = 1'b1;
    send(KA_IN, 1'b0);
    tick();
    tick();
    total++; if (col_idx !== 2'd2) begin bad++; $display("FAIL rst_pre_col: got %0d want 2", col_idx); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    total++; if (col_idx !== 2'd0) begin bad++; $display("FAIL rst_mid_col: got %0d want 0", col_idx); end
    total++; if (out_state !== '0) begin bad++; $display("FAIL rst_mid_state: got %h want 0", out_state); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(KA_IN, 1'b0);
    repeat (NCOL) tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_state !== KA_OUT) begin bad++; $display("FAIL rst_recover: got v=%b %h want 1 %h", out_valid, out_state, KA_OUT); end
    tick();
    tick();
  endtask

  task automatic test_flush();
    int seen;
    unit_fwd  = 1'b0;
    out_ready = 1'b1;
    send(rnd_state(), 1'b0);
    tick();
    flush = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_run_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_run_idle: busy=%b valid=%b want 0 0", busy, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_run_after: got %b want 1", in_ready); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_run_leak: got %0d valid cycles want 0", seen); end
    tick();
    out_ready = 1'b0;
    send(rnd_state(), 1'b0);
    repeat (NCOL) tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_done_pre: got %b want 1", out_valid); end
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = rnd_state();
    bypass    = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_done_ready: got %b want 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_done_drop: valid=%b busy=%b want 0 0", out_valid, busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_done_after: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_random();
    localparam int N = 30;
    logic [SW-1:0] exp_q [$];
    logic [SW-1:0] held;
    logic [SW-1:0] want;
    bit stalled;
    int acc, got, cyc;
    logic exp_ready;
    unit_fwd = 1'b0;
    acc = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < N && cyc < 2000) begin
      in_valid  = (acc < N) && ($urandom_range(0, 9) < 7);
      in_state  = rnd_state();
      bypass    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_ready = (!busy && !out_valid) || (out_valid && out_ready);
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_ready); end
      if (stalled) begin
        total++; if (out_valid !== 1'b1 || out_state !== held) begin bad++; $display("FAIL rnd_hold: got v=%b %h want 1 %h", out_valid, out_state, held); end
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        total++; if (out_state !== want) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", got, out_state, want); end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_state;
      if (in_valid && in_ready) begin
        exp_q.push_back(bypass ? in_state : state_xf(in_state, 1'b0));
        acc++;
      end
      tick();
      cyc++;
    end
    total++; if (got != N) begin bad++; $display("FAIL rnd_timeout: got %0d outputs want %0d", got, N); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_state = '0;
    bypass = 1'b0; out_ready = 1'b0; unit_fwd = 1'b0;
    test_reset();
    test_vector();
    test_backpressure();
    test_back_to_back();
    test_bypass();
    test_reset_midop();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
